// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared codes for alu_md: aluc encodings, md_op encodings
//                and the iterative engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Low three aluc bits select these ops regardless of aluc[3]
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110;

    // Shifts need all four bits to decode
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    // Multi-cycle operation codes (2'b11 is reserved and behaves as none)
    localparam logic [1:0] MD_NONE  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_md_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md_if
//  Description : Operand / result bundle between the execute stage and alu_md.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       aluc;
    logic [1:0]       md_op;
    logic             start;
    logic [WIDTH-1:0] s;
    logic             z;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, aluc, md_op, start,
        input  s, z, busy, done, hi, lo
    );

    modport slave (
        input  a, b, aluc, md_op, start,
        output s, z, busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_iter.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter
//  Description : Iterative unsigned multiply (shift-add) / divide (restoring),
//                one bit per clock, results committed to HI/LO on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_e          r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    // Multiplicand for MULTU, divisor for DIVU
    logic [WIDTH-1:0]   r_opnd;
    // Upper half: partial product / remainder; lower half: multiplier / quotient
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_accept = start && !busy && ((op == MD_MULTU) || (op == MD_DIVU));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // One iteration step of whichever operation is in flight
    always_comb begin
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
        w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_ge      = (w_trial >= {1'b0, r_opnd});
        // Remainder after subtraction is always below the divisor, so W bits suffice
        w_rem     = w_trial[WIDTH-1:0] - r_opnd;
        w_acc_nxt = r_acc;
        if (r_op == MD_DIVU) begin
            if (w_ge) begin
                w_acc_nxt = {w_rem, r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
        end else if (r_acc[0]) begin
            w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    // IDLE/RUN sequencer with latched operands and registered busy/done/HI/LO
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= MD_NONE;
            r_opnd  <= '0;
            r_acc   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_opnd  <= (op == MD_DIVU) ? b : a;
                        r_acc   <= (op == MD_DIVU) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        hi      <= w_acc_nxt[2*WIDTH-1:WIDTH];
                        lo      <= w_acc_nxt[WIDTH-1:0];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md
//  Description : Single-cycle ALU plus iterative MULTU/DIVU engine driving
//                architectural HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     resetn,
    alu_md_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_s;

    assign w_sh = bus.a[SHW-1:0];

    // Combinational result select; shifts are the only codes needing aluc[3]
    always_comb begin
        w_s = '0;
        case (bus.aluc[2:0])
            ALU_ADD: w_s = bus.a + bus.b;
            ALU_SUB: w_s = bus.a - bus.b;
            ALU_AND: w_s = bus.a & bus.b;
            ALU_OR:  w_s = bus.a | bus.b;
            ALU_XOR: w_s = bus.a ^ bus.b;
            ALU_LUI: w_s = bus.b << (WIDTH / 2);
            default: begin
                if (bus.aluc == ALU_SLL) begin
                    w_s = bus.b << w_sh;
                end else if (bus.aluc == ALU_SRL) begin
                    w_s = bus.b >> w_sh;
                end else if (bus.aluc == ALU_SRA) begin
                    w_s = $unsigned($signed(bus.b) >>> w_sh);
                end
            end
        endcase
    end

    assign bus.s = w_s;
    assign bus.z = (w_s == '0);

    md_iter #(
        .WIDTH (WIDTH)
    ) u_md_iter (
        .clock  (clock),
        .resetn (resetn),
        .start  (bus.start),
        .op     (bus.md_op),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (bus.busy),
        .done   (bus.done),
        .hi     (bus.hi),
        .lo     (bus.lo)
    );
endmodule
`default_nettype wire

// File: doc/alu_md.md
# alu_md

Parametrised successor of the single-cycle ALU, extended with an iterative multiply/divide unit.
- The combinational datapath keeps the existing 4-bit `aluc` encoding: ADD/SUB/AND/OR/XOR/LUI/SLL/SRL/SRA.
- A multi-cycle unsigned MULTU/DIVU engine writes architectural HI/LO registers through a start/busy/done handshake.
- Sits in the execute stage; the control unit stalls the PC while `busy` is high.

## Interface
- `WIDTH`, default 32: datapath width. Must be even, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width, derived; not overridden.
- `clock`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `a`  in  WIDTH: operand A. Shift amount for SLL/SRL/SRA is `a[SHW-1:0]`.
- `b`  in  WIDTH: operand B.
- `aluc`  in  4: combinational op select.
- `md_op`  in  2: multi-cycle op. 00 none, 01 MULTU, 10 DIVU, 11 reserved (treated as none).
- `start`  in  1: launch `md_op` with current `a`/`b`.
- `s`  out  WIDTH: combinational result.
- `z`  out  1: high when `s == 0`.
- `busy`  out  1: multi-cycle engine running.
- `done`  out  1: one-cycle pulse when HI/LO have been updated.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- **Combinational path** (independent of clock and state):
  - `aluc` x000 → a+b; x100 → a−b; x001 → a&b; x101 → a|b; x010 → a^b.
  - x110 → b << WIDTH/2.
  - 0011 → b << sh; 0111 → b >> sh (logical); 1111 → b >>> sh (arithmetic).
  - Any other code → 0. `z` follows `s`.
- **Launch:** accepted only when `start=1`, `busy=0` and `md_op` ∈ {01, 10}. Otherwise `start` is ignored, with no queueing.
  - On acceptance: `a`, `b` and op are latched, the iteration counter is cleared, and `busy` is set.
- **States:** IDLE → RUN → IDLE.
  - RUN performs exactly WIDTH iterations, one per clock.
  - On the WIDTH-th iteration edge: write HI/LO, clear `busy`, assert `done`. There is no DONE state; `done` is a registered flag.
- **MULTU:** shift-add over a 2·WIDTH accumulator. {hi, lo} = a × b, unsigned.
- **DIVU:** restoring division, one quotient bit per cycle. lo = a / b, hi = a % b.
- **Divide by zero:** lo = all ones, hi = a. Still takes WIDTH cycles, with no error flag.
- **HI/LO updates:** written only at completion. Partial results are never visible on `hi`/`lo`.
- **Reset:** `resetn` low at any time, including mid-RUN:
  - `busy`, `done`, `hi`, `lo` and the counter go to 0 immediately.
  - The in-flight operation is discarded.
- **Operand changes during RUN:** no effect, since operands are latched.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0. `s`/`z` are combinational from the inputs.
- Launch at rising edge k:
  - `busy`=1 after edge k, through edge k+WIDTH.
  - At edge k+WIDTH: `hi`/`lo` take their final values, `busy`→0, `done`→1.
  - At edge k+WIDTH+1: `done`→0, unless a new operation completes there, which is impossible.
- Latency from start edge to result visible: WIDTH cycles.
- Back-to-back: `start` may be high in the cycle where `done`=1, because `busy`=0 then. The new launch happens at edge k+WIDTH+1.
- `start` held high continuously relaunches on every idle cycle. This is legal; the requester must drop `start` after acceptance if single-shot.

## Structure
- Package `alu_pkg` holds:
  - localparams for the `aluc` codes;
  - `md_op` codes MD_NONE / MD_MULTU / MD_DIVU;
  - FSM state encoding IDLE / RUN.
- Sub-module `md_iter`: the iterative engine, containing the accumulator/remainder registers, counter and FSM.
  - It exposes `start`, `op`, `a`, `b`, `busy`, `done`, `hi`, `lo`.
- The top `alu_md` contains the combinational ALU plus the `md_iter` instance.

## Test plan
All scenarios use WIDTH=32.
1. **Combinational sweep:** `aluc`=0100, a=5, b=5 → s=0, z=1. `aluc`=1111, a=4, b=0x80000000 → s=0xF8000000. `aluc`=0110, b=0x1234 → s=0x12340000.
2. **MULTU:** a=0xFFFFFFFF, b=0xFFFFFFFF, pulse `start` → `busy` for exactly 32 cycles, then `done` pulse; hi=0xFFFFFFFE, lo=0x00000001.
3. **DIVU:** a=100, b=7 → lo=14, hi=2 after 32 cycles. With b=0, a=0x55 → lo=0xFFFFFFFF, hi=0x55.
4. **Start while busy:** MULTU 3×4, then `start` with DIVU at cycle 10 → ignored. Result hi=0, lo=12; `busy` length is unchanged.
5. **Reset mid-op:** launch MULTU 0x10000×0x10000, drop `resetn` at cycle 15 → `busy`, `done`, `hi`, `lo` all 0 asynchronously. After release, no `done` pulse appears.
6. **Back-to-back:** assert `start` in the `done` cycle with DIVU 9/2 → second `done` exactly 32 cycles later; lo=4, hi=1.
